// File: rtl/rvx_ram_arbiter_if.sv
// -----------------------------------------------------------------------------
// rvx_ram_arbiter_if
// One 32-bit RAM-style request/response port. The same bundle is used for the
// two upstream masters and for the downstream RAM port of rvx_ram_arbiter.
//
//   rw_address      32  byte address                     (requester -> responder)
//   read_request     1  read request                     (requester -> responder)
//   write_request    1  write request                    (requester -> responder)
//   write_data      32  write payload                    (requester -> responder)
//   write_strobe     4  byte enables                     (requester -> responder)
//   read_data       32  read return data                 (responder -> requester)
//   read_response    1  read completion                  (responder -> requester)
//   write_response   1  write completion                 (responder -> requester)
//
// Modports:
//   master  the side that issues requests (the arbiter towards the RAM)
//   slave   the side that answers requests (the arbiter towards each master)
// -----------------------------------------------------------------------------
interface rvx_ram_arbiter_if;
    logic [31:0] rw_address;
    logic        read_request;
    logic        write_request;
    logic [31:0] write_data;
    logic [3:0]  write_strobe;
    logic [31:0] read_data;
    logic        read_response;
    logic        write_response;

    modport master (
        output rw_address, read_request, write_request, write_data, write_strobe,
        input  read_data, read_response, write_response
    );

    modport slave (
        input  rw_address, read_request, write_request, write_data, write_strobe,
        output read_data, read_response, write_response
    );
endinterface

// File: rtl/rvx_ram_arbiter.sv
// -----------------------------------------------------------------------------
// rvx_ram_arbiter
// Two-master arbiter in front of a single RAM port. At most one transaction is
// outstanding: IDLE grants and latches a request, ISSUE pulses the RAM request
// for one cycle, WAIT holds the payload until the matching RAM response or a
// timeout, DONE returns the result to the granted master for one cycle.
//
// Ports:
//   clock        single clock, all state on its rising edge
//   reset_n      asynchronous active-low reset (deassertion synchronised by
//                the integrator)
//   m0, m1       master ports (slave modport of rvx_ram_arbiter_if)
//   s            downstream RAM port (master modport of rvx_ram_arbiter_if)
//   m0_timeout   one-cycle flag alongside a forced response to master 0
//   m1_timeout   one-cycle flag alongside a forced response to master 1
//
// Parameter:
//   TIMEOUT_CYCLES  WAIT cycles before a forced response (1..255)
//
// Configuration macro:
//   RVX_ARB_ROUND_ROBIN_EN  defined: a simultaneous request goes to the master
//                           not served last. Undefined: master 0 always wins
//                           and no priority register exists.
// -----------------------------------------------------------------------------
module rvx_ram_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                clock,
    input  logic                reset_n,
    rvx_ram_arbiter_if.slave    m0,
    rvx_ram_arbiter_if.slave    m1,
    rvx_ram_arbiter_if.master   s,
    output logic                m0_timeout,
    output logic                m1_timeout
);

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  wait_count;

    // Transaction latched at grant time; the masters may change their inputs
    // freely once the grant has been taken.
    logic [31:0] lat_address;
    logic [31:0] lat_write_data;
    logic [3:0]  lat_write_strobe;
    logic        lat_write;
    logic        lat_master;
    logic [31:0] lat_read_data;
    logic        lat_timeout;

    logic        req0;
    logic        req1;
    logic        grant;
    logic        grant_write;
    logic        s_response;
    logic        timeout_hit;
    logic        payload_valid;
    logic        done0;
    logic        done1;

    assign req0 = m0.read_request | m0.write_request;
    assign req1 = m1.read_request | m1.write_request;

`ifdef RVX_ARB_ROUND_ROBIN_EN
    // Master that wins the next simultaneous request.
    logic priority_master;

    assign grant = (req0 && req1) ? priority_master : req1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            priority_master <= 1'b0;
        end else if (state == WAIT && state_next == DONE) begin
            priority_master <= ~lat_master;
        end
    end
`else
    assign grant = ~req0;
`endif

    // A write wins over a read raised by the same master; the read remains
    // pending and is granted in a later IDLE cycle.
    assign grant_write = grant ? m1.write_request : m0.write_request;

    // Only the response type matching the issued operation completes WAIT.
    assign s_response  = lat_write ? s.write_response : s.read_response;

    // The counter holds the number of WAIT cycles already spent, so the
    // TIMEOUT_CYCLES-th WAIT cycle is the last one.
    assign timeout_hit = (wait_count + 8'd1) == TIMEOUT_LIMIT;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of process evaluation order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the default assignment at the top of a combinational block keeps
    // every path assigned, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req0 || req1) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (s_response || timeout_hit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the latched payload is reset as well, so the block starts from a
    // known transaction and no X can reach the outputs after reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_count       <= 8'd0;
            lat_address      <= 32'd0;
            lat_write_data   <= 32'd0;
            lat_write_strobe <= 4'd0;
            lat_write        <= 1'b0;
            lat_master       <= 1'b0;
            lat_read_data    <= 32'd0;
            lat_timeout      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        lat_master       <= grant;
                        lat_write        <= grant_write;
                        lat_address      <= grant ? m1.rw_address   : m0.rw_address;
                        lat_write_data   <= grant ? m1.write_data   : m0.write_data;
                        lat_write_strobe <= grant ? m1.write_strobe : m0.write_strobe;
                        lat_read_data    <= 32'd0;
                        lat_timeout      <= 1'b0;
                    end
                end
                ISSUE: begin
                    wait_count <= 8'd0;
                end
                WAIT: begin
                    wait_count <= wait_count + 8'd1;
                    if (s_response) begin
                        lat_read_data <= lat_write ? 32'd0 : s.read_data;
                    end else if (timeout_hit) begin
                        lat_read_data <= 32'd0;
                        lat_timeout   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Downstream port: payload visible only while the transaction is in
    // flight, request pulsed for the single ISSUE cycle.
    assign payload_valid  = (state == ISSUE) || (state == WAIT);
    assign s.rw_address   = payload_valid ? lat_address      : 32'd0;
    assign s.write_data   = payload_valid ? lat_write_data   : 32'd0;
    assign s.write_strobe = payload_valid ? lat_write_strobe : 4'd0;
    assign s.read_request  = (state == ISSUE) && !lat_write;
    assign s.write_request = (state == ISSUE) &&  lat_write;

    // Master return paths are decoded from state, so an asynchronous reset
    // clears them in the same instant.
    assign done0 = (state == DONE) && !lat_master;
    assign done1 = (state == DONE) &&  lat_master;

    assign m0.read_response  = done0 && !lat_write;
    assign m0.write_response = done0 &&  lat_write;
    assign m0.read_data      = (done0 && !lat_write) ? lat_read_data : 32'd0;
    assign m0_timeout        = done0 && lat_timeout;

    assign m1.read_response  = done1 && !lat_write;
    assign m1.write_response = done1 &&  lat_write;
    assign m1.read_data      = (done1 && !lat_write) ? lat_read_data : 32'd0;
    assign m1_timeout        = done1 && lat_timeout;

endmodule

// File: doc/rvx_ram_arbiter.md
RVX_RAM_ARBITER -- requirements
Module: rvx_ram_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15, range 1..255: cycles in WAIT before a forced response.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 mN_rw_address (N=0,1)  input  32  master N byte address.
REQ-005 mN_read_request / mN_write_request  input  1 each  master N requests, held high until the matching response.
REQ-006 mN_write_data  input  32, mN_write_strobe  input  4  master N write payload.
REQ-007 mN_read_data  output  32, mN_read_response / mN_write_response  output  1 each  master N return path.
REQ-008 mN_timeout  output  1  one-cycle flag, coincident with a forced response.
REQ-009 s_rw_address  output  32, s_write_data  output  32, s_write_strobe  output  4, s_read_request / s_write_request  output  1 each  downstream RAM port.
REQ-010 s_read_data  input  32, s_read_response / s_write_response  input  1 each  downstream RAM return path.

Function
REQ-011 FSM states: IDLE, ISSUE, WAIT, DONE; one transaction is outstanding at most.
REQ-012 IDLE: any mN read or write request pending -> grant per REQ-021, latch the granted master's address, data, strobe and operation, go to ISSUE; otherwise stay.
REQ-013 Same master with read and write both high: the write is served; the read stays pending for a later grant.
REQ-014 ISSUE, one cycle: s_read_request or s_write_request high, s_* payload = latched values -> WAIT.
REQ-015 s_* payload outputs hold the latched values in ISSUE and WAIT; they are zero in IDLE and DONE.
REQ-016 WAIT: matching s_*_response high -> capture s_read_data (0 for writes), go to DONE; counter increments each WAIT cycle.
REQ-017 Counter reaches TIMEOUT_CYCLES in WAIT -> go to DONE with data 0 and timeout flagged; the counter is 8 bits and clears on entry to WAIT.
REQ-018 DONE, one cycle: granted master's response and read_data driven, mN_timeout high if flagged -> IDLE; the other master's outputs stay 0.
REQ-019 Latency with a 1-cycle RAM: request sampled in IDLE at cycle 0; s request in cycle 1; s response in cycle 2; master response in cycle 3; next grant possible in cycle 4.
REQ-020 Master request still high in the IDLE cycle after its response counts as a new transaction; requests changing during ISSUE, WAIT or DONE are ignored.
REQ-021 Grant selection follows REQ-029 / REQ-030.
REQ-022 Spurious s_*_response outside WAIT, or of the non-issued type: ignored.
REQ-023 mN_read_data is 0 in every cycle where mN_read_response is low.

Reset
REQ-024 reset_n low, at any time: state IDLE, counter 0, priority pointer at master 0, latched registers 0.
REQ-025 During and after reset, every output is 0 until a new grant.
REQ-026 A transaction interrupted by reset is dropped without a response; a late s response after reset is ignored per REQ-022.
REQ-027 The reset release is not synchronised inside this block; the integrator supplies a synchronised deassertion.

Configuration
REQ-028 Macro RVX_ARB_ROUND_ROBIN_EN selects the arbitration policy.
REQ-029 RVX_ARB_ROUND_ROBIN_EN defined: on a simultaneous request, the master not served last wins; the pointer updates on entry to DONE.
REQ-030 RVX_ARB_ROUND_ROBIN_EN undefined: master 0 always wins a simultaneous request; no pointer register is implemented.

Verification
REQ-031 m0 reads 0x0000_0010 from a RAM preloaded with 0xDEADBEEF there -> m0_read_response high in cycle 3 only, with m0_read_data=0xDEADBEEF; m1 outputs stay 0.
REQ-032 m1 writes 0xA5A5A5A5 with strobe 4'b0011 to 0x20, then m1 reads 0x20 -> read data 0x0000A5A5 over preloaded 0; m1_write_response pulses once.
REQ-033 m0 and m1 request together for 4 back-to-back transactions -> grant order 0,1,0,1 with the macro defined; 0,0,0,0 with m1 starved while m0 holds its request, macro undefined.
REQ-034 s responses are tied low and m0 reads -> m0_read_response and m0_timeout high in cycle TIMEOUT_CYCLES+2 with data 0; the FSM returns to IDLE.
REQ-035 reset_n pulsed low in WAIT -> all outputs 0 immediately; the late s_read_response is ignored; the next m1 request completes normally in 3 cycles.
REQ-036 m0 raises read and write to 0x8 together -> the write is served first, then the read, which returns the newly written data.
